// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM encodings and
// command-byte field positions.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_CMD   = 2'd1,
        STATE_WRITE = 2'd2,
        STATE_READ  = 2'd3
    } state_t;

    // Bit of the command byte that selects read (1) or write (0).
    localparam int CMD_READ_BIT = 7;

    // Width of the register address carried in the command byte.
    localparam int ADDR_BITS = 7;

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8-bit register bank: one synchronous write port that ignores
// addresses beyond the bank, and a combinational read port that returns
// 8'h00 for addresses beyond the bank.
module spi_reg_bank
    import spi_bridge_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_BITS-1:0]      wr_addr,
    input  logic [7:0]                wr_data,
    input  logic [ADDR_BITS-1:0]      rd_addr,
    output logic [7:0]                rd_data,
    output logic [8*NUM_REGS-1:0]     regs
);

    // Storage update: only an address that matches an existing register
    // is written, so out-of-range writes have no effect.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs <= {NUM_REGS{RESET_VALUE}};
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_BITS'(i)) begin
                    regs[8*i +: 8] <= wr_data;
                end
            end
        end
    end

    // Read mux: zero unless the address selects an existing register.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_BITS'(i)) begin
                rd_data = regs[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Frames the SPI front end's byte stream into chip-select transactions:
// the first byte is a command (read/write + start address), following bytes
// write the register bank or clock out read data with auto-increment.
//
// Handshake: out_data is offered whenever out_data_valid is high; a byte is
// consumed on any cycle where out_data_valid & out_data_ready are both high.
// in_data_valid has no backpressure and is accepted on every cycle it pulses.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [7:0]  FILL_BYTE   = 8'hA5,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      active,
    input  logic                      in_data_valid,
    input  logic [7:0]                in_data,
    output logic                      out_data_valid,
    output logic [7:0]                out_data,
    input  logic                      out_data_ready,
    output logic [8*NUM_REGS-1:0]     regs,
    output logic                      wr_strobe,
    output logic [ADDR_BITS-1:0]      wr_addr,
    output logic [7:0]                wr_data,
    output state_t                    dbg_state
);

    state_t                 state, state_next;
    logic                   active_d;
    logic [ADDR_BITS-1:0]   addr_ptr, addr_next;
    logic [7:0]             tx_byte, tx_next;
    logic                   strobe_next;
    logic [ADDR_BITS-1:0]   wr_addr_next;
    logic [7:0]             wr_data_next;
    logic                   bank_we;
    logic [ADDR_BITS-1:0]   bank_raddr;
    logic [7:0]             bank_rdata;
    logic                   cs_rise, cs_fall, handshake;

    assign cs_rise   = active & ~active_d;
    assign cs_fall   = ~active & active_d;
    assign handshake = out_data_valid & out_data_ready;
    assign out_data  = tx_byte;
    assign dbg_state = state;

    spi_reg_bank #(
        .NUM_REGS    (NUM_REGS),
        .RESET_VALUE (RESET_VALUE)
    ) u_bank (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bank_we),
        .wr_addr (addr_ptr),
        .wr_data (in_data),
        .rd_addr (bank_raddr),
        .rd_data (bank_rdata),
        .regs    (regs)
    );

    // State, pointer, transmit byte and write-strobe registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= STATE_IDLE;
            active_d       <= 1'b0;
            out_data_valid <= 1'b0;
            addr_ptr       <= '0;
            tx_byte        <= FILL_BYTE;
            wr_strobe      <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= 8'h00;
        end else begin
            state          <= state_next;
            active_d       <= active;
            out_data_valid <= active;
            addr_ptr       <= addr_next;
            tx_byte        <= tx_next;
            wr_strobe      <= strobe_next;
            wr_addr        <= wr_addr_next;
            wr_data        <= wr_data_next;
        end
    end

    // Transaction decode; a chip-select fall is applied last so a byte
    // arriving in the same cycle is still processed before the abort.
    always_comb begin
        state_next   = state;
        addr_next    = addr_ptr;
        tx_next      = tx_byte;
        strobe_next  = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;
        bank_we      = 1'b0;
        bank_raddr   = addr_ptr;

        case (state)
            STATE_IDLE: begin
                if (cs_rise) begin
                    state_next = STATE_CMD;
                    tx_next    = FILL_BYTE;
                end
            end
            STATE_CMD: begin
                if (in_data_valid) begin
                    addr_next = in_data[ADDR_BITS-1:0];
                    if (in_data[CMD_READ_BIT]) begin
                        state_next = STATE_READ;
                        bank_raddr = in_data[ADDR_BITS-1:0];
                        tx_next    = bank_rdata;
                        addr_next  = in_data[ADDR_BITS-1:0] + 1'b1;
                    end else begin
                        state_next = STATE_WRITE;
                    end
                end
            end
            STATE_WRITE: begin
                if (in_data_valid) begin
                    bank_we      = 1'b1;
                    strobe_next  = 1'b1;
                    wr_addr_next = addr_ptr;
                    wr_data_next = in_data;
                    addr_next    = addr_ptr + 1'b1;
                end
            end
            STATE_READ: begin
                // Received bytes are dummy clocking bytes and are ignored.
                if (handshake) begin
                    tx_next   = bank_rdata;
                    addr_next = addr_ptr + 1'b1;
                end
            end
            default: state_next = STATE_IDLE;
        endcase

        if (cs_fall) begin
            state_next = STATE_IDLE;
            tx_next    = FILL_BYTE;
            addr_next  = '0;
        end
    end

endmodule
